// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_t;

    localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last_idx, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [NUM_REQ-1:0]         pick_oh,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx,
    output logic                       any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        pick_oh   = '0;
        pick_idx  = '0;
        any_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_idx) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any_valid && req[cand_idx]) begin
                any_valid         = 1'b1;
                pick_idx          = cand_idx;
                pick_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the shared FIFO write port.
// Optional per-requester transfer counters when ARB_STATS_EN is defined.
//
// state     | meaning
// ARB_IDLE  | no owner; pick next requester, no transfers this cycle
// ARB_BURST | owner locked; forward words until last or MAX_BURST beats
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
`ifdef ARB_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [NUM_REQ*STAT_WIDTH-1:0] grant_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   beat_q, beat_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (req_valid),
        .last_idx  (last_q),
        .pick_oh   (pick_oh),
        .pick_idx  (pick_idx),
        .any_valid (pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        logic xfer;
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        beat_d    = beat_q;
        req_ready = '0;
        fifo_wr   = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    beat_d  = '0;
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                req_ready[owner_q] = ~fifo_full;
                xfer               = req_valid[owner_q] & ~fifo_full;
                fifo_wr            = xfer;
                if (xfer) begin
                    beat_d = beat_q + CNT_W'(1);
                    // Truncate on the beat that reaches MAX_BURST even without last.
                    if (req_last[owner_q] || (beat_q == CNT_W'(MAX_BURST - 1))) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign fifo_wdata = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant      = grant_q;
    assign busy       = (state_q == ARB_BURST);

`ifdef ARB_STATS_EN
    logic [STAT_WIDTH-1:0] cnt_q [NUM_REQ];
    logic [STAT_WIDTH-1:0] cnt_d [NUM_REQ];

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            // Clear has priority over a same-cycle increment.
            if (stats_clr) begin
                cnt_d[i] = '0;
            end else if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + STAT_WIDTH'(1);
            end
            grant_cnt[i*STAT_WIDTH +: STAT_WIDTH] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues, round-robin reference model, negedge monitor.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MB = 8;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_wr;
    logic [DW-1:0]    fifo_wdata;
    logic [NR-1:0]    grant;
    logic             busy;
`ifdef ARB_STATS_EN
    logic             stats_clr;
    logic [NR*16-1:0] grant_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy)
`ifdef ARB_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        bit            is_end;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] pq_data[NR][$];
    bit            pq_last[NR][$];

    int            n_cmp = 0;
    int            n_bad = 0;
    int            model_last = NR - 1;
    int            full_pct = 0;
    int            bub_pct = 0;
    int            full_hold = 0;
    int            vhold[NR];
    int            beat_seen = 0;
    logic [NR-1:0] xfer_mask = '0;
    logic [NR-1:0] prev_grant = '0;
    bit            end_prev = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic push_word(input int i, input logic [DW-1:0] d, input bit l);
        pq_data[i].push_back(d);
        pq_last[i].push_back(l);
    endtask

    // Replays the round-robin rules over a snapshot of all producer queues.
    task automatic model_build();
        logic [DW-1:0] md[NR][$];
        bit            ml[NR][$];
        int            g;
        int            n;
        bit            found;
        bit            fin;
        exp_t          it;
        for (int i = 0; i < NR; i++) begin
            md[i] = pq_data[i];
            ml[i] = pq_last[i];
        end
        forever begin
            found = 0;
            g = 0;
            for (int off = 1; off <= NR; off++) begin
                int c;
                c = (model_last + off) % NR;
                if (!found && md[c].size() > 0) begin
                    found = 1;
                    g = c;
                end
            end
            if (!found) break;
            n = 0;
            fin = 0;
            while (!fin) begin
                it.owner  = g;
                it.data   = md[g].pop_front();
                n++;
                fin       = ml[g].pop_front() || (n == MB) || (md[g].size() == 0);
                it.is_end = fin;
                exp_q.push_back(it);
            end
            model_last = g;
        end
    endtask

    task automatic wait_drain();
        int cyc;
        logic [31:0] timed_out;
        cyc = 0;
        while ((exp_q.size() != 0 || grant != '0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = (cyc >= 3000) ? 32'd1 : 32'd0;
        chk("drain_timeout", timed_out, 32'd0);
        @(posedge clk);
    endtask

    task automatic wait_beats(input int owner, input int n);
        int cyc;
        logic [31:0] timed_out;
        cyc = 0;
        while (!(grant[owner] && beat_seen >= n) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = (cyc >= 500) ? 32'd1 : 32'd0;
        chk("beat_wait_timeout", timed_out, 32'd0);
        @(posedge clk);
    endtask

    task automatic flush_all();
        exp_q.delete();
        for (int i = 0; i < NR; i++) begin
            pq_data[i].delete();
            pq_last[i].delete();
            vhold[i] = 0;
        end
        full_hold  = 0;
        model_last = NR - 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        flush_all();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
    endtask

    // Producers: valid whenever words are queued; bubbles only while granted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (xfer_mask[i] && pq_data[i].size() > 0) begin
                    void'(pq_data[i].pop_front());
                    void'(pq_last[i].pop_front());
                end
            end
            if (full_hold > 0) begin
                fifo_full = 1'b1;
                full_hold--;
            end else begin
                fifo_full = ($urandom_range(99) < full_pct);
            end
            for (int i = 0; i < NR; i++) begin
                bit bub;
                bub = 0;
                if (grant[i]) begin
                    if (vhold[i] > 0) begin
                        bub = 1;
                        vhold[i]--;
                    end else if ($urandom_range(99) < bub_pct) begin
                        bub = 1;
                    end
                end
                if (pq_data[i].size() > 0) begin
                    req_valid[i]          = !bub;
                    req_data[i*DW +: DW]  = pq_data[i][0];
                    req_last[i]           = pq_last[i][0];
                end else begin
                    req_valid[i]          = 1'b0;
                    req_data[i*DW +: DW]  = DW'($urandom);
                    req_last[i]           = 1'($urandom_range(1));
                end
            end
        end
    end

    // Monitor: protocol rules every cycle, scoreboard on each FIFO write.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                xfer_mask  = '0;
                prev_grant = '0;
                end_prev   = 0;
                beat_seen  = 0;
            end else begin
                logic [NR-1:0] exp_rdy;
                bit            exp_wr;
                bit            this_end;
                exp_t          it;
                xfer_mask = req_valid & req_ready;
                exp_rdy   = (busy && !fifo_full) ? grant : '0;
                exp_wr    = ((grant & req_valid) != '0) && !fifo_full;
                chk("busy_vs_grant", 32'(busy), 32'(grant != '0));
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
                if (prev_grant != '0)
                    chk("grant_hold", 32'(grant), end_prev ? 32'd0 : 32'(prev_grant));
                if (prev_grant == '0 && grant != '0) beat_seen = 0;
                this_end = 0;
                if (fifo_wr) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got data %0h grant %0h expected no write at %0t",
                                 fifo_wdata, grant, $time);
                    end else begin
                        it = exp_q.pop_front();
                        chk("wr_owner", 32'(grant), 32'd1 << it.owner);
                        chk("wr_data", 32'(fifo_wdata), 32'(it.data));
                        this_end = it.is_end;
                        beat_seen++;
                    end
                end
                prev_grant = grant;
                end_prev   = this_end;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) vhold[i] = 0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        #2 reset = 1'b0;
        @(posedge clk);

        // Two requesters, 3-word bursts: expect 1,2,1,2.
        for (int k = 0; k < 6; k++) begin
            push_word(1, DW'(16'h1100 + k), (k % 3) == 2);
            push_word(2, DW'(16'h2200 + k), (k % 3) == 2);
        end
        model_build();
        wait_drain();

        // Long stream from R0 truncated at MAX_BURST, interleaved with R3.
        do_reset();
        for (int k = 0; k < 20; k++) push_word(0, DW'(16'h0A00 + k), k == 19);
        for (int k = 0; k < 4; k++) push_word(3, DW'(16'h3D00 + k), (k % 2) == 1);
        model_build();
        wait_drain();

        // FIFO full for 5 cycles mid-burst.
        for (int k = 0; k < 6; k++) push_word(1, DW'(16'h5100 + k), k == 5);
        model_build();
        wait_beats(1, 2);
        full_hold = 5;
        wait_drain();

        // Owner drops valid for 3 cycles mid-burst.
        for (int k = 0; k < 5; k++) push_word(2, DW'(16'h6200 + k), k == 4);
        model_build();
        wait_beats(2, 2);
        vhold[2] = 3;
        wait_drain();

        // Asynchronous reset mid-burst, then R0 wins first.
        for (int k = 0; k < 8; k++) push_word(1, DW'(16'h7100 + k), k == 7);
        model_build();
        wait_beats(1, 2);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_fifo_wr", 32'(fifo_wr), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd0);
        flush_all();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 2; k++) push_word(i, DW'(16'h8000 + i * 16 + k), k == 1);
        model_build();
        wait_drain();

`ifdef ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 10; k++) push_word(2, DW'(16'h9200 + k), k == 9);
        model_build();
        wait_drain();
        chk("grant_cnt_r2_10", 32'(grant_cnt[2*16 +: 16]), 32'd10);
        push_word(2, DW'(16'h9300), 1'b1);
        model_build();
        begin
            int cyc;
            cyc = 0;
            @(negedge clk);
            while (!(req_valid[2] && req_ready[2]) && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            stats_clr = 1'b1;
            @(posedge clk);
            #1 stats_clr = 1'b0;
            chk("grant_cnt_r2_clr", 32'(grant_cnt[2*16 +: 16]), 32'd0);
        end
        wait_drain();
`endif

        // Randomized rounds with FIFO backpressure and owner bubbles.
        full_pct = 25;
        bub_pct  = 15;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NR; i++) begin
                int n;
                n = $urandom_range(0, 10);
                for (int k = 0; k < n; k++)
                    push_word(i, DW'($urandom), (k == n - 1) || ($urandom_range(3) == 0));
            end
            model_build();
            wait_drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
